// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared types and helpers for the load hazard scoreboard.
// Optional feature macro: LHS_PERF_EN (adds the stall-cycle performance counter).
package load_hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int MAX_LD_DEF   = 4;
    localparam int CNT_W_DEF    = 2;
    localparam int RW_DEF       = $clog2(NUM_REGS_DEF);
    localparam int NUM_SRC      = 2;

    typedef logic [RW_DEF-1:0]    reg_idx_t;
    typedef logic [CNT_W_DEF-1:0] ld_cnt_t;

    // Source operand slots of an issuing uop.
    typedef enum logic {
        SRC_RS1 = 1'b0,
        SRC_RS2 = 1'b1
    } hazard_src_e;

    // A source stalls when it is read, is not r0, has loads in flight, and is
    // not being satisfied this very cycle by the last outstanding load's bypass.
    function automatic logic src_hazard(input logic used,
                                        input logic idx_zero,
                                        input logic cnt_zero,
                                        input logic bypass_last);
        return used & ~idx_zero & ~cnt_zero & ~bypass_last;
    endfunction

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// Issue / memory-return / status bundle between decode, memory and the scoreboard.
// master: the side driving uops and load returns; slave: the scoreboard.
interface load_hazard_scoreboard_if #(
    parameter int NUM_REGS = 16
) ();
    localparam int RW = $clog2(NUM_REGS);

    logic                iss_valid;
    logic                iss_ready;
    logic [RW-1:0]       iss_rs1;
    logic                iss_rs1_used;
    logic [RW-1:0]       iss_rs2;
    logic                iss_rs2_used;
    logic [RW-1:0]       iss_rd;
    logic                iss_is_ld;
    logic                flush;
    logic                ld_done_valid;
    logic [RW-1:0]       ld_done_rd;
    logic [NUM_REGS-1:0] ld_pending;
    logic                err;

    modport master (
        output iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
               iss_rd, iss_is_ld, flush, ld_done_valid, ld_done_rd,
        input  iss_ready, ld_pending, err
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
               iss_rd, iss_is_ld, flush, ld_done_valid, ld_done_rd,
        output iss_ready, ld_pending, err
    );
endinterface

// File: rtl/load_hazard_scoreboard_ld_cnt_bank.sv
// Per-register outstanding-load counters with a registered "any load pending" flag.
// r0 is never tracked: its counter and pending bit are tied to zero.
module load_hazard_scoreboard_ld_cnt_bank
    import load_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_valid,
    input  logic [RW-1:0]       inc_rd,
    input  logic                dec_valid,
    input  logic [RW-1:0]       dec_rd,
    output logic [CNT_W-1:0]    cnt [NUM_REGS],
    output logic [NUM_REGS-1:0] ld_pending
);

    localparam logic [CNT_W-1:0] SAT = '1;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign cnt[gi]        = '0;
            assign ld_pending[gi] = 1'b0;
        end else begin : g_track
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             pending_reg;
            logic             inc_hit;
            logic             dec_hit;

            assign inc_hit = inc_valid & (inc_rd == RW'(gi));
            // Returns against an empty counter are ignored here; the top flags them.
            assign dec_hit = dec_valid & (dec_rd == RW'(gi)) & (cnt_reg != '0);

            // Up/down step; a simultaneous inc and dec cancel, saturation holds.
            always_comb begin
                cnt_next = cnt_reg;
                if (inc_hit && !dec_hit && cnt_reg != SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end else if (dec_hit && !inc_hit) begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            // Counter and pending flag both track the post-update count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg     <= '0;
                    pending_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    pending_reg <= (cnt_next != '0);
                end
            end

            assign cnt[gi]        = cnt_reg;
            assign ld_pending[gi] = pending_reg;
        end
    end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Issue-side load-use scheduler: holds a uop while any source waits on an
// in-flight load, limits the number of outstanding loads, flags bogus returns.
// Optional feature macro: LHS_PERF_EN (adds perf_stall_cnt port and counter).
module load_hazard_scoreboard
    import load_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int MAX_LD   = MAX_LD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_hazard_scoreboard_if.slave bus
`ifdef LHS_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int RW  = $clog2(NUM_REGS);
    localparam int IFW = $clog2(MAX_LD + 1);
    localparam logic [IFW-1:0]   MAX_LD_V = IFW'(MAX_LD);
    localparam logic [CNT_W-1:0] SAT      = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [IFW-1:0]   inflight_reg;
    logic [IFW-1:0]   inflight_next;
    logic             err_reg;

    logic [RW-1:0]      src_idx [NUM_SRC];
    logic [NUM_SRC-1:0] src_used;
    logic [NUM_SRC-1:0] src_haz;

    logic rd_tracked;
    logic res_block;
    logic issue_ok;
    logic accept;
    logic inc;
    logic done_hit;
    logic done_bad;

    assign src_idx[int'(SRC_RS1)]  = bus.iss_rs1;
    assign src_idx[int'(SRC_RS2)]  = bus.iss_rs2;
    assign src_used[int'(SRC_RS1)] = bus.iss_rs1_used;
    assign src_used[int'(SRC_RS2)] = bus.iss_rs2_used;

    // Per-source hazard, with the same-cycle bypass of the last pending load as wakeup.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_haz[gi] = src_hazard(
            src_used[gi],
            src_idx[gi] == '0,
            cnt[src_idx[gi]] == '0,
            bus.ld_done_valid & (bus.ld_done_rd == src_idx[gi]) & (cnt[src_idx[gi]] == ONE)
        );
    end

    // Loads to r0 are untracked, so they never consume a tracking slot.
    assign rd_tracked = bus.iss_is_ld & (bus.iss_rd != '0);
    assign res_block  = rd_tracked & ((inflight_reg == MAX_LD_V) | (cnt[bus.iss_rd] == SAT));
    assign issue_ok   = ~(|src_haz) & ~res_block;

    // iss_ready deliberately ignores flush; flush only suppresses the state change.
    assign bus.iss_ready = issue_ok;
    assign accept        = bus.iss_valid & issue_ok & ~bus.flush;
    assign inc           = accept & rd_tracked;
    assign done_hit      = bus.ld_done_valid & (bus.ld_done_rd != '0) & (cnt[bus.ld_done_rd] != '0);
    assign done_bad      = bus.ld_done_valid & ~done_hit;

    load_hazard_scoreboard_ld_cnt_bank #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .RW       (RW)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_valid  (inc),
        .inc_rd     (bus.iss_rd),
        .dec_valid  (bus.ld_done_valid),
        .dec_rd     (bus.ld_done_rd),
        .cnt        (cnt),
        .ld_pending (bus.ld_pending)
    );

    // Total in-flight loads follow the same inc/dec rule as the per-register counters.
    always_comb begin
        inflight_next = inflight_reg;
        if (inc && !done_hit) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (done_hit && !inc) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    // In-flight total and the sticky error on returns with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            if (done_bad) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.err = err_reg;

`ifdef LHS_PERF_EN
    logic [31:0] perf_stall_cnt_reg;

    // Count cycles where a live (unflushed) uop is held at issue; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_reg <= '0;
        end else if (bus.iss_valid && !issue_ok && !bus.flush) begin
            perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Self-checking bench for load_hazard_scoreboard: directed scenarios plus
// randomized traffic compared against a per-register load-count model.
// Build with LHS_PERF_EN defined to also check the stall counter.
module tb_load_hazard_scoreboard;

    localparam int NR   = 16;
    localparam int MAXL = 4;
    localparam int SATV = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_hazard_scoreboard_if #(.NUM_REGS(NR)) bus ();
`ifdef LHS_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    load_hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef LHS_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: how many loads each register is still waiting for.
    int          m_cnt [NR];
    int          m_infl;
    bit          m_err;
    logic [31:0] m_perf;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_infl = 0;
        m_err  = 1'b0;
        m_perf = '0;
    endtask

    function automatic logic [NR-1:0] model_pending();
        logic [NR-1:0] p;
        p = '0;
        for (int r = 1; r < NR; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    // A source waits if it reads a register with loads outstanding, unless the
    // single remaining load is returning right now.
    function automatic bit model_src_wait(input int s, input bit used);
        bit bypass;
        bypass = bus.ld_done_valid && (int'(bus.ld_done_rd) == s) && (m_cnt[s] == 1);
        return used && s != 0 && m_cnt[s] > 0 && !bypass;
    endfunction

    function automatic bit model_ready();
        bit blocked;
        blocked = bus.iss_is_ld && bus.iss_rd != 0 &&
                  (m_infl == MAXL || m_cnt[bus.iss_rd] == SATV);
        return !model_src_wait(int'(bus.iss_rs1), bus.iss_rs1_used) &&
               !model_src_wait(int'(bus.iss_rs2), bus.iss_rs2_used) && !blocked;
    endfunction

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit ld, input bit fl, input bit dv, input int drd);
        bus.iss_valid     = v;
        bus.iss_rs1       = rs1[3:0];
        bus.iss_rs1_used  = u1;
        bus.iss_rs2       = rs2[3:0];
        bus.iss_rs2_used  = u2;
        bus.iss_rd        = rd[3:0];
        bus.iss_is_ld     = ld;
        bus.flush         = fl;
        bus.ld_done_valid = dv;
        bus.ld_done_rd    = drd[3:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_ready(input string tag, input bit exp);
        #1;
        check_val(tag, {63'd0, bus.iss_ready}, {63'd0, exp});
    endtask

    // One clock: check iss_ready mid-cycle, advance the model, check state after the edge.
    task automatic step(input string tag);
        bit rdy, acc, inc, dec;
        int rd, drd;
        @(negedge clk);
        rdy = model_ready();
        check_val({tag, "_rdy"}, {63'd0, bus.iss_ready}, {63'd0, rdy});
        rd  = int'(bus.iss_rd);
        drd = int'(bus.ld_done_rd);
        acc = bus.iss_valid && rdy && !bus.flush;
        inc = acc && bus.iss_is_ld && rd != 0;
        dec = bus.ld_done_valid && drd != 0 && m_cnt[drd] > 0;
        if (bus.ld_done_valid && !dec) m_err = 1'b1;
        if (bus.iss_valid && !rdy && !bus.flush) m_perf = m_perf + 32'd1;
        if (inc) m_cnt[rd]++;
        if (dec) m_cnt[drd]--;
        m_infl = m_infl + int'(inc) - int'(dec);
        @(posedge clk);
        #1;
        check_val({tag, "_pend"}, {48'd0, bus.ld_pending}, {48'd0, model_pending()});
        check_val({tag, "_err"}, {63'd0, bus.err}, {63'd0, m_err});
`ifdef LHS_PERF_EN
        check_val({tag, "_perf"}, {32'd0, perf_stall_cnt}, {32'd0, m_perf});
`endif
        $display("%0t %s acc=%0d ld=%0d rd=%0d done=%0d/%0d rdy=%0d pend=%04h err=%0d",
                 $time, tag, acc, bus.iss_is_ld, rd, bus.ld_done_valid, drd, rdy,
                 bus.ld_pending, bus.err);
    endtask

    task automatic drain();
        for (int r = 1; r < NR; r++) begin
            while (m_cnt[r] > 0) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r);
                step("drain");
            end
        end
        idle();
    endtask

    task automatic random_phase(input int n, input bit allow_bad);
        int rd, drd, start;
        bit dv;
        for (int i = 0; i < n; i++) begin
            dv  = 1'b0;
            drd = 0;
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, NR - 1);
                for (int k = 0; k < NR; k++) begin
                    if (!dv && m_cnt[(start + k) % NR] > 0) begin
                        dv  = 1'b1;
                        drd = (start + k) % NR;
                    end
                end
            end
            if (allow_bad && $urandom_range(0, 19) == 0) begin
                dv  = 1'b1;
                drd = $urandom_range(0, NR - 1);
            end
            rd = $urandom_range(0, 7);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, rd,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, dv, drd);
            step("rand");
        end
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_pend", {48'd0, bus.ld_pending}, 64'd0);
        check_val("reset_err", {63'd0, bus.err}, 64'd0);
`ifdef LHS_PERF_EN
        check_val("reset_perf", {32'd0, perf_stall_cnt}, 64'd0);
`endif

        // Load-use stall and same-cycle bypass wakeup.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step("t1_ld3");
        drive(1, 3, 1, 1, 1, 4, 0, 0, 0, 0);
        expect_ready("t1_stall", 1'b0);
        step("t1_add");
        drive(1, 3, 1, 1, 1, 4, 0, 0, 1, 3);
        expect_ready("t1_wake", 1'b1);
        step("t1_wake");
        idle();
        check_val("t1_pend3", {63'd0, bus.ld_pending[3]}, 64'd0);

        // Outstanding-load limit blocks loads only.
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step("t2_ld1");
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step("t2_ld2");
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step("t2_ld5");
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); step("t2_ld6");
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        expect_ready("t2_full", 1'b0);
        step("t2_ld7");
        drive(1, 9, 1, 10, 1, 8, 0, 0, 0, 0);
        expect_ready("t2_alu", 1'b1);
        step("t2_alu");
        drain();

        // Two loads to one register need two returns.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step("t3_ld3a");
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step("t3_ld3b");
        drive(1, 3, 1, 0, 0, 4, 0, 0, 1, 3);
        expect_ready("t3_one_left", 1'b0);
        step("t3_done1");
        drive(1, 3, 1, 0, 0, 4, 0, 0, 1, 3);
        expect_ready("t3_last", 1'b1);
        step("t3_done2");

        // Issue and return on the same register in one cycle.
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step("t4_ld2");
        drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 2); step("t4_both");
        drive(1, 0, 0, 2, 1, 4, 0, 0, 0, 0);
        expect_ready("t4_still", 1'b0);
        step("t4_rd2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2); step("t4_done");

        // Flushed load is not tracked; bogus return sets sticky err.
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        expect_ready("t5_flush_rdy", 1'b1);
        step("t5_flush");
        check_val("t5_pend4", {63'd0, bus.ld_pending[4]}, 64'd0);
        drive(1, 4, 1, 0, 0, 5, 0, 0, 0, 0);
        expect_ready("t5_rd4", 1'b1);
        step("t5_rd4");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step("t5_bad");
        check_val("t5_err", {63'd0, bus.err}, 64'd1);
        idle(); step("t5_hold1"); step("t5_hold2");

        // Five stalled cycles on one load.
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step("t6_ld5");
`ifdef LHS_PERF_EN
        begin
            logic [31:0] base;
            base = perf_stall_cnt;
            drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) step("t6_stall");
            check_val("t6_perf5", {32'd0, perf_stall_cnt - base}, 64'd5);
        end
`else
        drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("t6_stall");
`endif
        drain();

        random_phase(300, 1'b0);
        drain();

        // Asynchronous reset with three loads pending and err set.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("t7_bad");
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step("t7_ld1");
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step("t7_ld2");
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step("t7_ld3");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t7_async_pend", {48'd0, bus.ld_pending}, 64'd0);
        check_val("t7_async_err", {63'd0, bus.err}, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        random_phase(300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
